// File: rtl/core_pkg.sv
// Shared core definitions: register-file geometry, FSM state and requester ids.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  // Register-file write sequencer states.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Requester ids. The id is also the bit position in the arbiter grant vector.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter with a last-grant pointer.
// Latency: grant is combinational from valids and pointer; the pointer updates on the granting edge.
// Backpressure: the loser is simply not granted and must hold its request.
//
// Ports:
//   i_clk, i_rst   clock and synchronous active-high reset (pointer -> REQ_ALU)
//   i_en           grants are forced to zero while low
//   i_valid[1:0]   request per requester, indexed by req_id_e
//   o_grant[1:0]   one-hot grant, only ever set for a valid requester
//   o_grant_id     id of the granted requester (meaningful when |o_grant)
import core_pkg::*;

module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant,
  output req_id_e    o_grant_id
);

  req_id_e    r_last;
  logic [1:0] w_grant;

  always_comb begin
    w_grant = 2'b00;
    if (i_en) begin
      case (i_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        // On contention the requester that was not served last wins.
        2'b11:   w_grant = (r_last == REQ_ALU) ? 2'b10 : 2'b01;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign o_grant    = w_grant;
  assign o_grant_id = w_grant[1] ? REQ_MEM : REQ_ALU;

  // A grant always coincides with a valid, so every grant is a transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= REQ_ALU;
    end else if (|w_grant) begin
      r_last <= o_grant_id;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write port sequencer: clears all registers after reset, then round-robins ALU/load writebacks.
// Latency: a handshake in cycle N shows as the registered write strobe in cycle N+1.
// Backpressure: readies are held low during the clear; in RUN the losing requester waits with valid held.
//
// Ports:
//   clock, reset                      clock and synchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data   ALU writeback request channel
//   mem_valid/mem_ready/mem_rd/mem_data   load writeback request channel
//   regwrite/writereg/writedata       registered register-file write port
//   init_done                         registered, high once every register has been cleared
import core_pkg::*;

module regfile_write_arbiter #(
  parameter int NUM_REGS = 32,          // must equal 2**ADDR_W
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = XLEN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              regwrite,
  output logic [ADDR_W-1:0] writereg,
  output logic [DATA_W-1:0] writedata,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  state_e            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_regwrite;
  logic [ADDR_W-1:0] r_writereg;
  logic [DATA_W-1:0] r_writedata;
  logic              r_init_done;

  logic              w_run;
  logic [1:0]        w_grant;
  req_id_e           w_grant_id;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_rd;
  logic [DATA_W-1:0] w_data;

  assign w_run = (r_state == RUN);

  rr_arbiter2 u_arb (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_en       (w_run),
    .i_valid    ({mem_valid, alu_valid}),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id)
  );

  assign alu_ready = w_grant[REQ_ALU];
  assign mem_ready = w_grant[REQ_MEM];
  assign w_xfer    = |w_grant;
  assign w_rd      = (w_grant_id == REQ_MEM) ? mem_rd   : alu_rd;
  assign w_data    = (w_grant_id == REQ_MEM) ? mem_data : alu_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= CLEAR;
      r_cnt       <= '0;
      r_regwrite  <= 1'b0;
      r_writereg  <= '0;
      r_writedata <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_regwrite  <= 1'b1;
          r_writereg  <= r_cnt;
          r_writedata <= '0;
          r_cnt       <= r_cnt + 1'b1;
          // init_done rises with the final clear strobe, so RUN starts the cycle it is visible.
          if (r_cnt == LAST_REG) begin
            r_state     <= RUN;
            r_init_done <= 1'b1;
          end
        end
        RUN: begin
          if (w_xfer) begin
            // x0 is hardwired: accept the request but suppress the strobe.
            r_regwrite  <= (w_rd != '0);
            r_writereg  <= w_rd;
            r_writedata <= w_data;
          end else begin
            r_regwrite  <= 1'b0;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign regwrite  = r_regwrite;
  assign writereg  = r_writereg;
  assign writedata = r_writedata;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          alu_valid, mem_valid;
  logic          alu_ready, mem_ready;
  logic [AW-1:0] alu_rd, mem_rd;
  logic [DW-1:0] alu_data, mem_data;
  logic          regwrite, init_done;
  logic [AW-1:0] writereg;
  logic [DW-1:0] writedata;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  regfile_write_arbiter #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .regwrite  (regwrite),
    .writereg  (writereg),
    .writedata (writedata),
    .init_done (init_done)
  );

  typedef struct {
    logic          av;
    logic [AW-1:0] ard;
    logic [DW-1:0] ad;
    logic          mv;
    logic [AW-1:0] mrd;
    logic [DW-1:0] md;
    logic          e_ardy;
    logic          e_mrdy;
    logic          e_rw;
    logic [AW-1:0] e_wr;
    logic [DW-1:0] e_wd;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Walks clear edges first..last, checking the zero-write strobe on each.
  // Pointer is at ALU after reset, so on the last edge MEM wins any contention.
  task automatic check_clear(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(posedge clock); #1;
      chk($sformatf("clr%0d_rw", i), {31'd0, regwrite}, 32'd1);
      chk($sformatf("clr%0d_wr", i), {27'd0, writereg}, i);
      chk($sformatf("clr%0d_wd", i), writedata, 32'd0);
      chk($sformatf("clr%0d_done", i), {31'd0, init_done}, (i == NR - 1) ? 32'd1 : 32'd0);
      if (i < NR - 1) begin
        chk($sformatf("clr%0d_ardy", i), {31'd0, alu_ready}, 32'd0);
        chk($sformatf("clr%0d_mrdy", i), {31'd0, mem_ready}, 32'd0);
      end else begin
        chk("clr_last_mrdy", {31'd0, mem_ready}, {31'd0, mem_valid});
        chk("clr_last_ardy", {31'd0, alu_ready}, {31'd0, alu_valid & ~mem_valid});
      end
    end
  endtask

  task automatic reset_state_checks(input string tag);
    chk({tag, "_rw"},   {31'd0, regwrite},  32'd0);
    chk({tag, "_wr"},   {27'd0, writereg},  32'd0);
    chk({tag, "_wd"},   writedata,          32'd0);
    chk({tag, "_done"}, {31'd0, init_done}, 32'd0);
    chk({tag, "_ardy"}, {31'd0, alu_ready}, 32'd0);
    chk({tag, "_mrdy"}, {31'd0, mem_ready}, 32'd0);
  endtask

  initial begin
    //            av    ard    ad             mv    mrd    md             ardy  mrdy  rw    wr     wd
    vt[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF};
    vt[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF};
    vt[2]  = '{1'b1, 5'd1,  32'hA1A1A1A1, 1'b1, 5'd2,  32'hB2B2B2B2, 1'b0, 1'b1, 1'b1, 5'd2,  32'hB2B2B2B2};
    vt[3]  = '{1'b1, 5'd1,  32'hA1A1A1A1, 1'b1, 5'd2,  32'hB2B2B2B2, 1'b1, 1'b0, 1'b1, 5'd1,  32'hA1A1A1A1};
    vt[4]  = '{1'b1, 5'd1,  32'hA1A1A1A1, 1'b1, 5'd2,  32'hB2B2B2B2, 1'b0, 1'b1, 1'b1, 5'd2,  32'hB2B2B2B2};
    vt[5]  = '{1'b1, 5'd1,  32'hA1A1A1A1, 1'b1, 5'd2,  32'hB2B2B2B2, 1'b1, 1'b0, 1'b1, 5'd1,  32'hA1A1A1A1};
    vt[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h00001234, 1'b0, 1'b1, 1'b0, 5'd0,  32'h00001234};
    vt[7]  = '{1'b1, 5'd3,  32'h00000033, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd3,  32'h00000033};
    vt[8]  = '{1'b1, 5'd9,  32'h00000009, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd9,  32'h00000009};
    vt[9]  = '{1'b1, 5'd10, 32'h0000000A, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd10, 32'h0000000A};
    vt[10] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd31, 32'hFFFFFFFF};
    vt[11] = '{1'b1, 5'd0,  32'h00000055, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'h00000055};
    vt[12] = '{1'b1, 5'd4,  32'h44444444, 1'b1, 5'd6,  32'h66666666, 1'b0, 1'b1, 1'b1, 5'd6,  32'h66666666};
    vt[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd6,  32'h66666666};

    reset     = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;

    repeat (2) @(posedge clock);
    #1;
    reset_state_checks("rst");

    // Release with both requesters already asking: they must be ignored during the clear.
    @(negedge clock);
    reset     = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'h88;
    check_clear(0, NR - 1);
    // Withdraw before any edge: no transfer has happened yet.
    alu_valid = 1'b0;
    mem_valid = 1'b0;

    for (int k = 0; k < 14; k++) begin
      @(negedge clock);
      alu_valid = vt[k].av; alu_rd = vt[k].ard; alu_data = vt[k].ad;
      mem_valid = vt[k].mv; mem_rd = vt[k].mrd; mem_data = vt[k].md;
      #1;
      chk($sformatf("v%0d_ardy", k), {31'd0, alu_ready}, {31'd0, vt[k].e_ardy});
      chk($sformatf("v%0d_mrdy", k), {31'd0, mem_ready}, {31'd0, vt[k].e_mrdy});
      @(posedge clock); #1;
      chk($sformatf("v%0d_rw", k), {31'd0, regwrite}, {31'd0, vt[k].e_rw});
      chk($sformatf("v%0d_wr", k), {27'd0, writereg}, {27'd0, vt[k].e_wr});
      chk($sformatf("v%0d_wd", k), writedata, vt[k].e_wd);
    end

    // Reset in the middle of RUN drops the pointer back to ALU.
    @(negedge clock);
    reset = 1'b1;
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(posedge clock); #1;
    reset_state_checks("run_rst");

    // Reset again once the clear has issued registers 0..9.
    @(negedge clock);
    reset = 1'b0;
    check_clear(0, 9);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    reset_state_checks("clr_rst");
    @(negedge clock);
    reset = 1'b0;
    check_clear(0, NR - 1);

    // Pointer was MEM before reset; after reset it is ALU, so MEM wins first.
    @(negedge clock);
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h22;
    #1;
    chk("post_rst_mrdy", {31'd0, mem_ready}, 32'd1);
    chk("post_rst_ardy", {31'd0, alu_ready}, 32'd0);
    @(posedge clock); #1;
    chk("post_rst_wr", {27'd0, writereg}, 32'd2);
    chk("post_rst_wd", writedata, 32'h22);
    @(negedge clock);
    alu_valid = 1'b0; mem_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Sequencer and arbiter for the core's single register-file write port. After reset it runs a clear sequence that writes zero to all 32 registers, then shares the write port between the ALU writeback and load (memory) writeback requesters with valid/ready handshakes and round-robin priority. It sits between the writeback stage and the register file's `regwrite`/`writereg`/`writedata` inputs. Register x0 is kept at zero by construction.

## Interface
- `NUM_REGS`, 32, number of architectural registers cleared at init
- `ADDR_W`, 5, register address width; `NUM_REGS` == 2**`ADDR_W`
- `DATA_W`, 32, register data width

- `clock`  in  1  rising-edge clock, shared with the register file
- `reset`  in  1  synchronous, active-high reset
- `alu_valid`  in  1  ALU writeback request
- `alu_ready`  out  1  ALU request accepted this cycle
- `alu_rd`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `mem_valid`  in  1  load writeback request
- `mem_ready`  out  1  load request accepted this cycle
- `mem_rd`  in  ADDR_W  load destination register
- `mem_data`  in  DATA_W  load data
- `regwrite`  out  1  register-file write strobe (registered)
- `writereg`  out  ADDR_W  register-file write address (registered)
- `writedata`  out  DATA_W  register-file write data (registered)
- `init_done`  out  1  high once the clear sequence completes (registered)

## Operation
- States: CLEAR and RUN. Reset forces CLEAR, `cnt`=0, last-grant pointer = ALU (so MEM wins first contention).
- CLEAR: on each edge, output regs load {regwrite=1, writereg=cnt, writedata=0}, then `cnt`++. The edge that issues `cnt`==NUM_REGS-1 moves the state to RUN and sets `init_done`=1. Both readies are held at 0 in CLEAR.
- RUN, ready is combinational and depends only on the valids and the pointer:
  - Only one valid: that requester gets ready=1.
  - Both valid: grant goes to the requester that was not granted last.
  - Neither valid: no grant.
- A transfer is valid && ready. The pointer updates only on a transfer.
- Transfer: on the same edge, output regs load {regwrite=(rd!=0), writereg=rd, writedata=data}. Writes to x0 are accepted (ready=1) but not written (regwrite=0).
- No transfer in RUN: regwrite<=0. writereg/writedata hold their previous values.
- At most one transfer per cycle. The losing requester must hold valid, rd and data stable until it is accepted.

## Timing
- Reset values: regwrite=0, writereg=0, writedata=0, init_done=0, alu_ready=0, mem_ready=0.
- Clear takes exactly NUM_REGS cycles. regwrite is high on the NUM_REGS consecutive cycles following the first edge with reset low.
- `init_done` rises together with the last clear strobe. The first ready can assert in that same cycle.
- Latency: a transfer in cycle N produces the regwrite strobe in cycle N+1, and the register file captures the data at the end of N+1.
- Back-to-back transfers from one requester are allowed every cycle when the other requester is idle.
- Reset mid-clear or mid-RUN: the clear restarts from register 0, any pending output write is dropped, and the pointer returns to ALU.
- Valid asserted during CLEAR: ignored until RUN. No request is lost as long as the requester holds it.

## Structure
- Shared package (`core_pkg`):
  - `REG_ADDR_W`=5, `XLEN`=32.
  - State enum {CLEAR, RUN}.
  - Requester id encoding ALU=0, MEM=1.
- One natural sub-module, `rr_arbiter2`: a 2-input round-robin arbiter that takes the valids and the pointer, produces the grants, and updates the pointer on transfer. It is reusable for other shared ports.
- The clear counter, FSM and output registers live in the top module.

## Test plan
- Reset 2 cycles, then release → regwrite=1 for 32 consecutive cycles with writereg 0..31 and writedata=0; init_done=1 on the 32nd; readies 0 throughout.
- RUN, alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle → alu_ready=1 that cycle; the next cycle shows regwrite=1, writereg=5, writedata=0xDEADBEEF.
- Both valid for 4 cycles (alu_rd=1, mem_rd=2) → grants MEM, ALU, MEM, ALU; regwrite strobes writereg 2, 1, 2, 1.
- mem_valid=1, mem_rd=0, mem_data=0x1234 → mem_ready=1; the next cycle has regwrite=0.
- Reset asserted at clear cycle 10 and released → clear restarts at writereg=0 and completes 32 cycles later; init_done stays 0 until then.
- alu_valid held continuously with mem idle → alu_ready=1 every cycle; regwrite=1 on every following cycle.
